// File: rtl/norm_shifter_32bits_pkg.sv
// Shared types and constants for the 32-bit normalizer: FSM states,
// search step count, mode encodings and the binary-search step-size table.
package norm_pkg;

  localparam int DATA_W     = 32;
  localparam int NORM_STEPS = 5;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } norm_state_t;

  // Shift distance tried at search step k: 16, 8, 4, 2, 1.
  function automatic logic [4:0] step_size(input logic [2:0] k);
    logic [4:0] s;
    case (k)
      3'd0:    s = 5'd16;
      3'd1:    s = 5'd8;
      3'd2:    s = 5'd4;
      3'd3:    s = 5'd2;
      3'd4:    s = 5'd1;
      default: s = 5'd0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/norm_shifter_32bits_if.sv
// Operand/result handshake bundle for the normalizer.
// The slave side is the normalizer; the master side feeds operands and takes results.
interface norm_shifter_32bits_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic        Mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Y;
  logic [5:0]  N;
  logic        Zero;

  modport master (
    output in_valid, A, Mode, out_ready,
    input  in_ready, out_valid, Y, N, Zero
  );

  modport slave (
    input  in_valid, A, Mode, out_ready,
    output in_ready, out_valid, Y, N, Zero
  );

endinterface

// File: rtl/norm_shifter_32bits_step.sv
// One binary-search step: if the top `step` bits of the search word are
// all zero, shift search word and working value left by `step` and add it to the count.
module norm_step
  import norm_pkg::*;
(
  input  logic [DATA_W-1:0] t,
  input  logic [DATA_W-1:0] w,
  input  logic [4:0]        c,
  input  logic [4:0]        step,
  output logic [DATA_W-1:0] t_next,
  output logic [DATA_W-1:0] w_next,
  output logic [4:0]        c_next
);

  logic [DATA_W-1:0] top_mask_s;

  // Conditional shift when the examined high field of the search word is empty.
  always_comb begin
    top_mask_s = ~({DATA_W{1'b1}} >> step);
    t_next     = t;
    w_next     = w;
    c_next     = c;
    if ((t & top_mask_s) == {DATA_W{1'b0}}) begin
      t_next = t << step;
      w_next = w << step;
      c_next = c + step;
    end else begin
      t_next = t;
      w_next = w;
      c_next = c;
    end
  end

endmodule

// File: rtl/norm_shifter_32bits.sv
// Multi-cycle 32-bit normalizer: finds N so that A << N is normalized
// (leading zeros for unsigned, redundant sign bits for signed) via a 5-step binary search.
module norm_shifter_32bits
  import norm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  norm_shifter_32bits_if.slave  bus
);

  norm_state_t       state_r;
  norm_state_t       state_s;

  logic [WIDTH-1:0]  t_r;
  logic [WIDTH-1:0]  w_r;
  logic [4:0]        c_r;
  logic [2:0]        k_r;
  logic              mode_r;
  logic              a_zero_r;

  logic              in_ready_r;
  logic              out_valid_r;
  logic [WIDTH-1:0]  y_r;
  logic [5:0]        n_r;
  logic              zero_r;

  logic [WIDTH-1:0]  t_init_s;
  logic [WIDTH-1:0]  t_nxt_s;
  logic [WIDTH-1:0]  w_nxt_s;
  logic [4:0]        c_nxt_s;
  logic              accept_s;
  logic              last_step_s;

  assign accept_s    = bus.in_valid & (state_r == IDLE);
  assign last_step_s = (state_r == SEARCH) && (k_r == 3'(NORM_STEPS - 1));

  // Signed mode searches for the first bit differing from the sign bit.
  always_comb begin
    t_init_s = bus.A;
    if (bus.Mode == MODE_SIGNED) begin
      t_init_s = (bus.A ^ {WIDTH{bus.A[WIDTH-1]}}) << 1;
    end else begin
      t_init_s = bus.A;
    end
  end

  norm_step u_step (
    .t      (t_r),
    .w      (w_r),
    .c      (c_r),
    .step   (step_size(k_r)),
    .t_next (t_nxt_s),
    .w_next (w_nxt_s),
    .c_next (c_nxt_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) state_s = SEARCH;
        else              state_s = IDLE;
      end
      SEARCH: begin
        if (last_step_s) state_s = DONE;
        else             state_s = SEARCH;
      end
      DONE: begin
        if (bus.out_ready) state_s = IDLE;
        else               state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Operand capture, search datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_r         <= '0;
      w_r         <= '0;
      c_r         <= 5'd0;
      k_r         <= 3'd0;
      mode_r      <= MODE_UNSIGNED;
      a_zero_r    <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      y_r         <= '0;
      n_r         <= 6'd0;
      zero_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            t_r        <= t_init_s;
            w_r        <= bus.A;
            c_r        <= 5'd0;
            k_r        <= 3'd0;
            mode_r     <= bus.Mode;
            a_zero_r   <= (bus.A == {WIDTH{1'b0}});
            in_ready_r <= 1'b0;
          end
        end
        SEARCH: begin
          t_r <= t_nxt_s;
          w_r <= w_nxt_s;
          c_r <= c_nxt_s;
          k_r <= k_r + 3'd1;
          if (last_step_s) begin
            y_r         <= w_nxt_s;
            // The step sum tops out at 31; unsigned zero is the only N=32 case.
            n_r         <= ((mode_r == MODE_UNSIGNED) && a_zero_r) ? 6'd32 : {1'b0, c_nxt_s};
            zero_r      <= a_zero_r;
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.Y         = y_r;
  assign bus.N         = n_r;
  assign bus.Zero      = zero_r;

endmodule

// File: tb/tb_norm_shifter_32bits.sv
// Directed self-checking bench for norm_shifter_32bits: boundary results,
// latency, backpressure, operand stability and reset during a search.
module tb_norm_shifter_32bits;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  norm_shifter_32bits_if bus ();

  norm_shifter_32bits #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, presents one operand, returns cycles from accept to out_valid.
  task automatic do_op(input logic mode, input logic [31:0] a, output int lat);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      tick();
      guard++;
    end
    bus.Mode     = mode;
    bus.A        = a;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_cmp++; if (bus.Y !== 32'h0) begin n_bad++; $display("FAIL reset_Y got=%h exp=0", bus.Y); end
    n_cmp++; if (bus.N !== 6'd0) begin n_bad++; $display("FAIL reset_N got=%0d exp=0", bus.N); end
    n_cmp++; if (bus.Zero !== 1'b0) begin n_bad++; $display("FAIL reset_Zero got=%b exp=0", bus.Zero); end
  endtask

  task automatic test_vectors(input logic mode);
    logic [31:0] av [6];
    logic [31:0] yv [6];
    logic [5:0]  nv [6];
    logic        zv [6];
    int          lat;
    if (mode == 1'b0) begin
      av = '{32'h0000_0001, 32'h0000_0000, 32'h8000_0001, 32'h0001_2345, 32'h00F0_0000, 32'h0000_0003};
      yv = '{32'h8000_0000, 32'h0000_0000, 32'h8000_0001, 32'h91A2_8000, 32'hF000_0000, 32'hC000_0000};
      nv = '{6'd31, 6'd32, 6'd0, 6'd15, 6'd8, 6'd30};
      zv = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    end else begin
      av = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_0000, 32'h0000_1234, 32'h4000_0000, 32'hBFFF_FFFF};
      yv = '{32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 32'h48D0_0000, 32'h4000_0000, 32'hBFFF_FFFF};
      nv = '{6'd31, 6'd31, 6'd15, 6'd18, 6'd0, 6'd0};
      zv = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    end
    for (int i = 0; i < 6; i++) begin
      do_op(mode, av[i], lat);
      n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL latency m=%b A=%h got=%0d exp=5", mode, av[i], lat); end
      n_cmp++; if (bus.N !== nv[i]) begin n_bad++; $display("FAIL N m=%b A=%h got=%0d exp=%0d", mode, av[i], bus.N, nv[i]); end
      n_cmp++; if (bus.Y !== yv[i]) begin n_bad++; $display("FAIL Y m=%b A=%h got=%h exp=%h", mode, av[i], bus.Y, yv[i]); end
      n_cmp++; if (bus.Zero !== zv[i]) begin n_bad++; $display("FAIL Zero m=%b A=%h got=%b exp=%b", mode, av[i], bus.Zero, zv[i]); end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    do_op(1'b0, 32'h00F0_0000, lat);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", i, bus.out_valid); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, bus.in_ready); end
      n_cmp++; if (bus.N !== 6'd8) begin n_bad++; $display("FAIL bp_N cyc=%0d got=%0d exp=8", i, bus.N); end
      n_cmp++; if (bus.Y !== 32'hF000_0000) begin n_bad++; $display("FAIL bp_Y cyc=%0d got=%h exp=f0000000", i, bus.Y); end
      tick();
    end
    release_result();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_out_valid got=%b exp=0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_in_ready got=%b exp=1", bus.in_ready); end
    n_cmp++; if (bus.Y !== 32'hF000_0000) begin n_bad++; $display("FAIL bp_hold_Y got=%h exp=f0000000", bus.Y); end
    n_cmp++; if (bus.N !== 6'd8) begin n_bad++; $display("FAIL bp_hold_N got=%0d exp=8", bus.N); end
  endtask

  task automatic test_operand_stability();
    int lat;
    int ready_seen;
    bus.Mode     = 1'b0;
    bus.A        = 32'h0000_0100;
    bus.in_valid = 1'b1;
    tick();
    bus.A    = 32'hFFFF_FFFF;
    bus.Mode = 1'b1;
    lat = 0;
    ready_seen = 0;
    while (!bus.out_valid && lat < 50) begin
      if (bus.in_ready) ready_seen++;
      tick();
      lat++;
    end
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL stab_latency got=%0d exp=5", lat); end
    n_cmp++; if (ready_seen !== 0) begin n_bad++; $display("FAIL stab_in_ready_cycles got=%0d exp=0", ready_seen); end
    n_cmp++; if (bus.N !== 6'd23) begin n_bad++; $display("FAIL stab_N got=%0d exp=23", bus.N); end
    n_cmp++; if (bus.Y !== 32'h8000_0000) begin n_bad++; $display("FAIL stab_Y got=%h exp=80000000", bus.Y); end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL stab_done_hold got=%b exp=1", bus.out_valid); end
    bus.in_valid = 1'b0;
    release_result();
  endtask

  task automatic test_reset_mid_search();
    int lat;
    bus.Mode     = 1'b0;
    bus.A        = 32'h0000_0001;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_in_ready got=%b exp=1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_out_valid got=%b exp=0", bus.out_valid); end
    n_cmp++; if (bus.Y !== 32'h0) begin n_bad++; $display("FAIL mid_rst_Y got=%h exp=0", bus.Y); end
    n_cmp++; if (bus.N !== 6'd0) begin n_bad++; $display("FAIL mid_rst_N got=%0d exp=0", bus.N); end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_no_result cyc=%0d got=%b exp=0", i, bus.out_valid); end
    end
    do_op(1'b1, 32'h0000_1234, lat);
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL post_rst_latency got=%0d exp=5", lat); end
    n_cmp++; if (bus.N !== 6'd18) begin n_bad++; $display("FAIL post_rst_N got=%0d exp=18", bus.N); end
    n_cmp++; if (bus.Y !== 32'h48D0_0000) begin n_bad++; $display("FAIL post_rst_Y got=%h exp=48d00000", bus.Y); end
    release_result();
  endtask

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = 32'h0;
    bus.Mode      = 1'b0;
    test_reset();
    test_vectors(1'b0);
    test_vectors(1'b1);
    test_backpressure();
    test_operand_stability();
    test_reset_mid_search();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/norm_shifter_32bits.md
Name: norm_shifter_32bits

Overview:
Multi-cycle 32-bit normalizer; the inverse companion of the 32-bit barrel shifter. The shifter takes A and a shift amount and produces Y. This block takes A and finds the left-shift amount N that normalizes it, then returns both N and the normalized Y = A << N. It uses a 5-step binary search (16/8/4/2/1 bits), one step per cycle, with valid/ready handshakes on both sides. It sits beside the shifter in the ALU / fixed-point datapath, feeding N back as the shifter's B.

Parameters:
WIDTH, 32, datapath width; only 32 is supported (5 search steps are hard-coded).

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  A and Mode are valid
in_ready  output  1  block can accept an operand
A  input  32  operand
Mode  input  1  0 = unsigned (count leading zeros); 1 = signed (count redundant sign bits)
out_valid  output  1  Y, N and Zero are valid
out_ready  input  1  consumer accepts the result
Y  output  32  normalized value, A << N with zero fill
N  output  6  shift amount, 0..32
Zero  output  1  A was 0

Behaviour:
- Reset, sampled on clk edge while rst=1:
  - state returns to IDLE
  - in_ready=1, out_valid=0, Y=0, N=0, Zero=0
  - rst overrides any operation in flight; a partial result is discarded.
- States are IDLE, SEARCH, DONE.
- in_ready = (state==IDLE). There is no overlap, so throughput is 1 result per 7 cycles minimum.
- Accept happens on the edge where in_valid & in_ready:
  - latch A and Zero = (A==0)
  - search word T: Mode=0 gives T=A; Mode=1 gives T=(A ^ {32{A[31]}}) << 1
  - working value W=A, count C=0, step k=0; go to SEARCH
- Operands are sampled only at accept. A and Mode changing afterwards have no effect.
- SEARCH, one step per edge, for k=0..4 with S = 16,8,4,2,1:
  - if T[31:32-S]==0: T <<= S, W <<= S, C += S
  - after step k=4, go to DONE
- Latency: accept edge E, out_valid=1 in the cycle following edge E+5.
- DONE:
  - out_valid=1; Y=W; N=C, except unsigned A==0 where N=32.
  - Outputs hold stable while out_ready=0.
  - On the edge with out_valid & out_ready: out_valid goes to 0 and state goes to IDLE. in_ready rises the next cycle.
  - Y, N and Zero hold their last values after the handshake until the next DONE.
- Boundary results:

| Mode | A | N | Y | Zero |
|---|---|---|---|---|
| 0 | 0 | 32 | 0 | 1 |
| 0 | bit31 set | 0 | A | 0 |
| 1 | 0 | 31 | 0 | 1 |
| 1 | 0xFFFFFFFF | 31 | 0x80000000 | 0 |
| 1 | A[31] != A[30] | 0 | A | 0 |

- Width rules:
  - C never exceeds 31 (16+8+4+2+1); the value 32 arises only from the zero special case.
  - Shifts inside the block are logical left, zero-filled.
- in_valid held high during SEARCH/DONE is ignored (not accepted) until IDLE.
- out_ready high outside DONE has no effect.

Decomposition:
- Shared package norm_pkg:
  - state enum norm_state_t {IDLE, SEARCH, DONE}
  - constant NORM_STEPS=5
  - step-size function/table {16,8,4,2,1}
  - MODE_UNSIGNED=1'b0, MODE_SIGNED=1'b1
- One sub-module, norm_step:
  - combinational; inputs T, W, C and step size
  - outputs next T, W, C
  - instantiated once and reused across cycles, selected by k.

Test Plan:
- Mode=0, A=0x00000001 → after 6 cycles out_valid=1, N=31, Y=0x80000000, Zero=0.
- Mode=0, A=0x00000000 → N=32, Y=0, Zero=1. Then Mode=1, A=0 → N=31, Y=0, Zero=1.
- Mode=1, A=0xFFFF0000 → N=15, Y=0x80000000. Mode=1, A=0x00001234 → N=18, Y=0x48D00000.
- Backpressure: Mode=0, A=0x00F00000 gives N=8, Y=0xF0000000.
  - Hold out_ready=0 for 4 cycles → outputs stable, in_ready=0.
  - Assert out_ready → out_valid=0 next cycle, in_ready=1.
- Operand stability: change A to 0xFFFFFFFF during SEARCH → result still matches the latched A. in_valid held high during SEARCH → no second accept.
- Reset mid-SEARCH: assert rst at step k=2 → next cycle state IDLE, out_valid=0, Y=0, N=0, in_ready=1. A new operand then completes normally.
